// File: rtl/uart_code_rx.sv
// uart_code_rx: UART byte receiver plus header/lo/hi/checksum framer producing 16-bit motion codes.
// Bit timing is counter based on clk; rx is resynchronised before any edge detection or sampling.
module uart_code_rx #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] Code,
    output logic        code_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW  = $clog2(TMO + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GW-1:0] G_TMO  = GW'(TMO);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [1:0] {F_HDR, F_LO, F_HI, F_CHK} fstate_t;

    bstate_t         b;
    fstate_t         f;
    logic            rx_m, rx_s, rx_d;
    logic [CW-1:0]   b_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg, lo, hi;
    logic [GW-1:0]   gap;
    logic            counting, tmo, start, samp_stop, byte_done, stop_err;

    assign counting  = (f != F_HDR) && (b == B_IDLE);
    assign tmo       = counting && (gap == G_TMO);
    // A start edge coinciding with the timeout is dropped in favour of the timeout.
    assign start     = (b == B_IDLE) && rx_d && !rx_s && !tmo;
    assign samp_stop = (b == B_STOP) && (b_cnt == C_LAST);
    assign byte_done = samp_stop && rx_s;
    assign stop_err  = samp_stop && !rx_s;
    assign busy      = (f != F_HDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b       <= B_IDLE;
            b_cnt   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (b)
                B_IDLE: begin
                    b_cnt   <= '0;
                    bit_idx <= '0;
                    if (start) b <= B_START;
                end
                B_START: begin
                    if (b_cnt == C_HALF) begin
                        b_cnt <= '0;
                        b     <= rx_s ? B_IDLE : B_DATA;
                    end else b_cnt <= b_cnt + 1'b1;
                end
                B_DATA: begin
                    if (b_cnt == C_LAST) begin
                        b_cnt   <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) b <= B_STOP;
                    end else b_cnt <= b_cnt + 1'b1;
                end
                B_STOP: begin
                    if (b_cnt == C_LAST) begin
                        b_cnt <= '0;
                        b     <= B_IDLE;
                    end else b_cnt <= b_cnt + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f          <= F_HDR;
            Code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            lo         <= '0;
            hi         <= '0;
            gap        <= '0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            gap        <= (counting && !start && !tmo) ? gap + 1'b1 : '0;
            if (tmo || stop_err) begin
                frame_err <= 1'b1;
                f         <= F_HDR;
            end else if (byte_done) begin
                case (f)
                    F_HDR: if (shreg == HDR_BYTE) f <= F_LO;
                    F_LO: begin
                        lo <= shreg;
                        f  <= F_HI;
                    end
                    F_HI: begin
                        hi <= shreg;
                        f  <= F_CHK;
                    end
                    F_CHK: begin
                        if (shreg == (HDR_BYTE ^ lo ^ hi)) begin
                            Code       <= {hi, lo};
                            code_valid <= 1'b1;
                        end else frame_err <= 1'b1;
                        f <= F_HDR;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_code_rx.sv
// tb_uart_code_rx: directed frames at 16 clocks per bit with hand-computed codes and pulse counts.
module tb_uart_code_rx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] Code;
    logic        code_valid, frame_err, busy;

    int n_checks = 0, n_pass = 0;
    int n_valid = 0, n_err = 0, n_wide = 0;
    int v0, e0;
    logic pv = 1'b0, pe = 1'b0;

    uart_code_rx #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .reset(reset), .rx(rx), .Code(Code),
        .code_valid(code_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) n_valid++;
        if (frame_err) n_err++;
        if ((code_valid && pv) || (frame_err && pe)) n_wide++;
        pv = code_valid;
        pe = frame_err;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_code", Code, 16'h0000);
        check("rst_valid", code_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);

        snap();
        send_byte(8'hA5, 1'b1);
        check("bad_busy_hdr", busy, 1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(2);
        check("bad_valid_cnt", n_valid - v0, 0);
        check("bad_err_cnt", n_err - e0, 1);
        check("bad_code", Code, 16'h0000);
        check("bad_busy_end", busy, 0);

        snap();
        send_byte(8'hA5, 1'b1);
        check("a_busy_hdr", busy, 1);
        send_byte(8'h34, 1'b1);
        check("a_busy_lo", busy, 1);
        send_byte(8'h12, 1'b1);
        check("a_busy_hi", busy, 1);
        send_byte(8'h83, 1'b1);
        check("a_busy_end", busy, 0);
        check("a_valid_cnt", n_valid - v0, 1);
        check("a_err_cnt", n_err - e0, 0);
        check("a_code", Code, 16'h1234);

        snap();
        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("garb_err_cnt", n_err - e0, 0);
        check("garb_busy", busy, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(2);
        check("garb_code", Code, 16'hABCD);
        check("garb_valid_cnt", n_valid - v0, 1);
        check("garb_err_cnt2", n_err - e0, 0);

        snap();
        idle(20);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_valid_cnt", n_valid - v0, 0);
        check("glitch_err_cnt", n_err - e0, 0);
        check("glitch_busy", busy, 0);
        check("glitch_code", Code, 16'hABCD);

        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(300);
        check("tmo_busy_before", busy, 1);
        check("tmo_err_before", n_err - e0, 0);
        idle(40);
        check("tmo_err_cnt", n_err - e0, 1);
        check("tmo_busy_after", busy, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h8B, 1'b1);
        idle(2);
        check("tmo_next_code", Code, 16'h5678);
        check("tmo_next_valid", n_valid - v0, 1);

        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(32);
        check("stop_err_cnt", n_err - e0, 1);
        check("stop_valid_cnt", n_valid - v0, 0);
        check("stop_busy", busy, 0);
        check("stop_code", Code, 16'h5678);

        snap();
        send_byte(8'hA5, 1'b1);
        rx = 1'b0;
        idle(2 * CPB);
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("mid_rst_code", Code, 16'h0000);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", code_valid, 0);
        check("mid_rst_err", frame_err, 0);
        idle(40);
        check("mid_rst_valid_cnt", n_valid - v0, 0);
        check("mid_rst_err_cnt", n_err - e0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'h9A, 1'b1);
        send_byte(8'h83, 1'b1);
        idle(2);
        check("post_rst_code", Code, 16'h9ABC);
        check("post_rst_valid_cnt", n_valid - v0, 1);
        check("post_rst_err_cnt", n_err - e0, 0);
        check("pulse_width", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
